// File: rtl/seven_seg_mux_driver_if.sv
// Display-side signal bundle for the two-digit seven-segment multiplex driver.
// The producer drives the digits and the enable. The driver returns segments and anodes.
interface seven_seg_mux_driver_if;
  logic [3:0] left;
  logic [3:0] right;
  logic       disp_en;
  logic [6:0] seg;
  logic       an_left;
  logic       an_right;

  modport master (
    output left, right, disp_en,
    input  seg, an_left, an_right
  );

  modport slave (
    input  left, right, disp_en,
    output seg, an_left, an_right
  );
endinterface

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed two-digit seven-segment driver with blanking gaps between digits.
// Each digit is latched only when its on-phase begins.
module seven_seg_mux_driver #(
  parameter int unsigned REFRESH_DIV    = 24000,
  parameter int unsigned BLANK_CYCLES   = 240,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  seven_seg_mux_driver_if.slave bus
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       AN_ON   = AN_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic       AN_OFF  = AN_ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam logic [1:0] BLANK_RL = 2'd0;
  localparam logic [1:0] LEFT_ON  = 2'd1;
  localparam logic [1:0] BLANK_LR = 2'd2;
  localparam logic [1:0] RIGHT_ON = 2'd3;

  logic [1:0]    state, nextstate;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    left_q, left_nxt;
  logic [3:0]    right_q, right_nxt;
  logic [6:0]    seg_q, seg_nxt;
  logic          an_left_q, an_left_nxt;
  logic          an_right_q, an_right_nxt;

  // Hex glyph in gfedcba order, adjusted for segment polarity.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] raw;
    case (d)
      4'h0: raw = 7'h3F;
      4'h1: raw = 7'h06;
      4'h2: raw = 7'h5B;
      4'h3: raw = 7'h4F;
      4'h4: raw = 7'h66;
      4'h5: raw = 7'h6D;
      4'h6: raw = 7'h7D;
      4'h7: raw = 7'h07;
      4'h8: raw = 7'h7F;
      4'h9: raw = 7'h6F;
      4'hA: raw = 7'h77;
      4'hB: raw = 7'h7C;
      4'hC: raw = 7'h39;
      4'hD: raw = 7'h5E;
      4'hE: raw = 7'h79;
      default: raw = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BLANK_RL;
      cnt        <= '0;
      left_q     <= '0;
      right_q    <= '0;
      seg_q      <= SEG_OFF;
      an_left_q  <= AN_OFF;
      an_right_q <= AN_OFF;
    end else begin
      state      <= nextstate;
      cnt        <= cnt_nxt;
      left_q     <= left_nxt;
      right_q    <= right_nxt;
      seg_q      <= seg_nxt;
      an_left_q  <= an_left_nxt;
      an_right_q <= an_right_nxt;
    end
  end

  // Phase sequencing, digit capture on on-phase entry, and outputs derived from nextstate.
  always_comb begin
    nextstate    = state;
    cnt_nxt      = cnt + CW'(1);
    left_nxt     = left_q;
    right_nxt    = right_q;
    seg_nxt      = SEG_OFF;
    an_left_nxt  = AN_OFF;
    an_right_nxt = AN_OFF;

    case (state)
      BLANK_RL: if (cnt == BLANK_LAST) begin
        nextstate = LEFT_ON;
        cnt_nxt   = '0;
        left_nxt  = bus.left;
      end
      LEFT_ON: if (cnt == ON_LAST) begin
        nextstate = BLANK_LR;
        cnt_nxt   = '0;
      end
      BLANK_LR: if (cnt == BLANK_LAST) begin
        nextstate = RIGHT_ON;
        cnt_nxt   = '0;
        right_nxt = bus.right;
      end
      RIGHT_ON: if (cnt == ON_LAST) begin
        nextstate = BLANK_RL;
        cnt_nxt   = '0;
      end
      default: begin
        nextstate = BLANK_RL;
        cnt_nxt   = '0;
      end
    endcase

    // Blanking only masks the outputs; sequencing and captures above are unaffected.
    if (bus.disp_en) begin
      case (nextstate)
        LEFT_ON: begin
          seg_nxt     = seg_code(left_nxt);
          an_left_nxt = AN_ON;
        end
        RIGHT_ON: begin
          seg_nxt      = seg_code(right_nxt);
          an_right_nxt = AN_ON;
        end
        default: ;
      endcase
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an_left  = an_left_q;
  assign bus.an_right = an_right_q;

endmodule

// File: doc/seven_seg_mux_driver.md
Name: seven_seg_mux_driver

Overview:
Time-multiplexed driver for the two-digit seven-segment display.
- Consumes the 4-bit hex digits (left, right) produced by the keypad decoder stage directly upstream.
- Alternately drives one shared segment bus and two digit anodes.
- Inserts a blanking gap between digits to prevent ghosting.
- Captures each digit only at the start of its on-phase, so a digit never changes mid-display.

Parameters:
REFRESH_DIV, 24000, clock cycles each digit is lit per on-phase; must be >= 2
BLANK_CYCLES, 240, clock cycles with both anodes off between on-phases; must be >= 1
SEG_ACTIVE_LOW, 1, 1 = segment lit when its seg bit is 0
AN_ACTIVE_LOW, 0, 1 = anode enabled when its an bit is 0

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
left  input  4  hex digit for the left display
right  input  4  hex digit for the right display
disp_en  input  1  1 = display on; 0 = blank all outputs while the FSM keeps running
seg  output  7  segment bus {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
an_left  output  1  left digit enable, polarity set by AN_ACTIVE_LOW
an_right  output  1  right digit enable, polarity set by AN_ACTIVE_LOW

Behaviour:
- One clock domain.
- Reset is asynchronous and active-low: all registers clear immediately on reset low, with no clock edge required.
- FSM states, cycled in order: BLANK_RL -> LEFT_ON -> BLANK_LR -> RIGHT_ON -> BLANK_RL.
- Phase counter:
  - Clears to 0 on every state entry and increments each cycle.
  - ON states exit when the counter equals REFRESH_DIV-1.
  - BLANK states exit when the counter equals BLANK_CYCLES-1.
  - Counter width is clog2(max(REFRESH_DIV, BLANK_CYCLES)).
- Full period is 2*(REFRESH_DIV+BLANK_CYCLES) cycles, with no drift.
- Reset state:
  - FSM in BLANK_RL, counter 0, left_q = right_q = 0.
  - seg = all segments off (7'h7F when SEG_ACTIVE_LOW = 1).
  - Both anodes inactive.
- After reset release: BLANK_CYCLES blank cycles, then LEFT_ON.
- Digit capture:
  - left_q is loaded from left on the cycle the FSM enters LEFT_ON.
  - right_q is loaded from right on the cycle the FSM enters RIGHT_ON.
  - Input changes at any other time are ignored until the next capture.
- Outputs are registered and computed from nextstate, so they align exactly with the state:
  - an_left is active exactly in the cycles where state = LEFT_ON.
  - an_right is active exactly in the cycles where state = RIGHT_ON.
  - seg shows decode(left_q) during LEFT_ON and decode(right_q) during RIGHT_ON.
  - seg is all-off in both BLANK states.
- Decode table, active-high, gfedcba:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
  - SEG_ACTIVE_LOW inverts all bits.
- Both anodes are never active in the same cycle, under any input, including disp_en toggles.
- disp_en = 0:
  - Next registered output cycle: seg all-off, both anodes inactive.
  - FSM, counter and digit captures continue unchanged.
  - On return to 1: outputs resume for the current state, showing the already-captured digit.
- Reset asserted mid-operation: outputs go to reset values immediately.
- Illegal state encoding: next state is BLANK_RL with counter 0.

Test Plan:
Bench parameters for all scenarios: REFRESH_DIV = 4, BLANK_CYCLES = 2, SEG_ACTIVE_LOW = 1, AN_ACTIVE_LOW = 0, disp_en = 1. Cycle 0 is the first posedge after reset release.
1. Hold reset low, then release -> seg = 7'h7F and an = 00 during reset and in cycles 0-1; an_left = 1 in cycles 2-5; blank in cycles 6-7; an_right = 1 in cycles 8-11; pattern repeats with period 12.
2. left = 4'h1, right = 4'hA -> seg = 7'h79 while an_left = 1; seg = 7'h08 while an_right = 1; seg = 7'h7F in every blank cycle.
3. Change left from 4'h1 to 4'h8 in the second cycle of LEFT_ON -> seg stays 7'h79 for the rest of that phase; shows 7'h00 from the next LEFT_ON.
4. Run 10 periods with random left/right changes every cycle -> an_left & an_right never both 1; every blank gap is exactly 2 cycles.
5. Drop disp_en for 5 cycles starting mid-RIGHT_ON -> outputs all-off; phase timing unchanged. Raise disp_en during LEFT_ON -> left digit shown for the remaining cycles of that phase.
6. Assert reset asynchronously, between clock edges, during RIGHT_ON -> seg = 7'h7F and an = 00 before the next posedge; after release, the sequence from scenario 1 repeats exactly.
